// File: rtl/ns_gnrl_burst_arb_if.sv
// Purpose: bundle of upstream requester beats, shared downstream beat port and arbiter status.
// Latency: none; this is only wiring shared between the arbiter and its neighbours.
// Backpressure: standard valid/ready on each side; req_ready is per requester.
// Ports:
//   req_valid/req_data/req_last/req_urgent  upstream beats (requester i at data bits [i*DW +: DW])
//   req_ready                               per-requester beat accepted
//   out_valid/out_data/out_last/out_ready   shared downstream beat port
//   out_src/busy/err_long                   owner index, burst locked, sticky long-burst flag
// Modports: master is taken by the arbiter (it masters the downstream port and answers the
// requesters); slave is the surrounding environment (requesters plus downstream sink).
interface ns_gnrl_burst_arb_if #(
  parameter int REQ_NUM = 4,
  parameter int DW      = 32
);
  localparam int SW = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]    req_valid;
  logic [REQ_NUM*DW-1:0] req_data;
  logic [REQ_NUM-1:0]    req_last;
  logic [REQ_NUM-1:0]    req_ready;
  logic [REQ_NUM-1:0]    req_urgent;
  logic                  out_valid;
  logic [DW-1:0]         out_data;
  logic                  out_last;
  logic                  out_ready;
  logic [SW-1:0]         out_src;
  logic                  busy;
  logic                  err_long;

  modport master (
    input  req_valid, req_data, req_last, req_urgent, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src, busy, err_long
  );

  modport slave (
    output req_valid, req_data, req_last, req_urgent, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src, busy, err_long
  );
endinterface

// File: rtl/ns_gnrl_burst_arb.sv
// Purpose: per-burst round-robin arbiter sharing one downstream valid/ready beat port.
// Latency: 1 cycle from first request to grant, beats then pass combinationally; >=1 bubble between bursts.
// Backpressure: out_ready goes straight to the owner's req_ready; non-owners are held without ready.
// Ports: clk, rst (async, active-high), arb (ns_gnrl_burst_arb_if.master): upstream req_*,
//   downstream out_*, status out_src (current/last owner), busy (burst locked), err_long (sticky).
// Optional: define NS_ARB_QOS_EN to restrict the idle round-robin search to urgent requesters
//   whenever any valid requester is urgent; otherwise req_urgent is ignored.
module ns_gnrl_burst_arb #(
  parameter int REQ_NUM   = 4,
  parameter int DW        = 32,
  parameter int MAX_BEATS = 16
) (
  input logic                 clk,
  input logic                 rst,
  ns_gnrl_burst_arb_if.master arb
);
  localparam int SW = $clog2(REQ_NUM);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             state;
  logic [SW-1:0]      ptr;
  logic [SW-1:0]      owner;
  logic [CW-1:0]      beat_cnt;
  logic               err_long_q;

  logic [REQ_NUM-1:0] cand;
  logic               grant_found;
  logic [SW-1:0]      grant_idx;
  logic               own_valid;
  logic               own_last;
  logic [DW-1:0]      own_data;
  logic [REQ_NUM-1:0] ready_v;
  logic               beat_acc;

  // Candidate set for the idle search.
`ifdef NS_ARB_QOS_EN
  always_comb begin
    cand = arb.req_valid;
    if (|(arb.req_valid & arb.req_urgent)) begin
      cand = arb.req_valid & arb.req_urgent;
    end
  end
`else
  logic unused_urgent;
  assign unused_urgent = ^arb.req_urgent;

  always_comb begin
    cand = arb.req_valid;
  end
`endif

  // Round-robin search starting at ptr. The index sum is one bit wider than ptr so the
  // wrap works for non-power-of-two REQ_NUM as well.
  always_comb begin
    logic [SW:0] sum;
    sum         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      sum = {1'b0, ptr} + (SW+1)'(k);
      if (sum >= (SW+1)'(REQ_NUM)) begin
        sum = sum - (SW+1)'(REQ_NUM);
      end
      if (!grant_found && cand[sum[SW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = sum[SW-1:0];
      end
    end
  end

  // Owner mux; constant indices keep the data select narrow.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    ready_v   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (owner == SW'(i)) begin
        own_valid  = arb.req_valid[i];
        own_last   = arb.req_last[i];
        own_data   = arb.req_data[i*DW +: DW];
        ready_v[i] = (state == LOCK) & arb.out_ready;
      end
    end
  end

  assign beat_acc      = (state == LOCK) & own_valid & arb.out_ready;

  assign arb.out_valid = (state == LOCK) & own_valid;
  assign arb.out_data  = own_data;
  assign arb.out_last  = own_last;
  assign arb.req_ready = ready_v;
  assign arb.out_src   = owner;
  assign arb.busy      = (state == LOCK);
  assign arb.err_long  = err_long_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      beat_cnt   <= '0;
      err_long_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            owner      <= grant_idx;
            beat_cnt   <= '0;
            err_long_q <= 1'b0;
            state      <= LOCK;
          end
        end
        LOCK: begin
          if (beat_acc) begin
            if (beat_cnt != CW'(MAX_BEATS)) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
            // Flag only; the burst keeps flowing until its own last beat.
            if (!own_last && (beat_cnt == CW'(MAX_BEATS - 1))) begin
              err_long_q <= 1'b1;
            end
            if (own_last) begin
              ptr   <= (owner == SW'(REQ_NUM - 1)) ? '0 : owner + 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ns_gnrl_burst_arb.sv
// Bench for ns_gnrl_burst_arb: directed burst scenarios followed by a randomized phase,
// all cycles checked against a transaction-level reference of the arbitration rules.
module tb_ns_gnrl_burst_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;
`ifdef NS_ARB_QOS_EN
  localparam int QOS_FIRST = 1;
`else
  localparam int QOS_FIRST = 0;
`endif

  logic clk;
  logic rst;

  ns_gnrl_burst_arb_if #(.REQ_NUM(N), .DW(DW)) bus ();

  ns_gnrl_burst_arb #(.REQ_NUM(N), .DW(DW), .MAX_BEATS(MB)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // requester stimulus state
  int            bq[N][$];
  int            rem[N];
  int            bix[N];
  int            bid[N];
  int            pause[N];
  bit            vld[N];
  bit            lst_a[N];
  logic [DW-1:0] dat[N];
  int            rdy_mode = 0;
  bit            pause_en = 0;
  bit            rnd_urg  = 0;
  logic [N-1:0]  urg      = '0;

  // reference model: owner/pointer/flag of the arbiter in spec terms
  bit m_lock;
  int m_own, m_ptr, m_src, m_cnt;
  bit m_err;

  // DUT observations
  int   g_log[$];
  int   a_src[$];
  int   a_cyc[$];
  logic a_last[$];
  logic a_err[$];
  bit   prev_busy = 0;

  int e1_src[4] = '{0, 0, 2, 2};
  int e1_cyc[4] = '{1, 2, 4, 5};
  int e2_g[3]   = '{3, 0, 3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_lock = 0; m_own = 0; m_ptr = 0; m_src = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic clear_drv();
    for (int i = 0; i < N; i++) begin
      bq[i].delete();
      rem[i] = 0; bix[i] = 0; pause[i] = 0;
    end
  endtask

  function automatic bit work_left();
    bit w;
    w = m_lock;
    for (int i = 0; i < N; i++) if (rem[i] > 0 || bq[i].size() > 0) w = 1;
    return w;
  endfunction

  task automatic drive();
    logic [N-1:0]    v, l;
    logic [N*DW-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0 && bq[i].size() > 0) begin
        rem[i] = bq[i].pop_front();
        bix[i] = 0;
        bid[i]++;
      end
      vld[i]   = (rem[i] > 0) && (pause[i] == 0);
      lst_a[i] = (rem[i] == 1);
      dat[i]   = DW'((i << 24) | ((bid[i] & 255) << 16) | bix[i]);
      v[i]     = vld[i];
      l[i]     = lst_a[i];
      d[i*DW +: DW] = dat[i];
    end
    bus.req_valid  = v;
    bus.req_last   = l;
    bus.req_data   = d;
    bus.req_urgent = rnd_urg ? N'($urandom) : urg;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (cyc % 2 == 0);
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // One clock: check outputs at negedge against the model, advance the model with the
  // inputs held for this cycle, then update stimulus just after the rising edge.
  task automatic step();
    logic [N-1:0] cand, rdy_exp;
    bit acc, lst;
    int own_b, best, bd, d;
    @(negedge clk);
    rdy_exp = '0;
    if (m_lock) rdy_exp[m_own] = bus.out_ready;
    chk("busy",      64'(bus.busy),      64'(m_lock));
    chk("out_src",   64'(bus.out_src),   64'(m_src));
    chk("err_long",  64'(bus.err_long),  64'(m_err));
    chk("req_ready", 64'(bus.req_ready), 64'(rdy_exp));
    chk("out_valid", 64'(bus.out_valid), 64'(m_lock && vld[m_own]));
    if (m_lock && vld[m_own]) begin
      chk("out_data", 64'(bus.out_data), 64'(dat[m_own]));
      chk("out_last", 64'(bus.out_last), 64'(lst_a[m_own]));
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      a_src.push_back(int'(bus.out_src));
      a_cyc.push_back(cyc);
      a_last.push_back(bus.out_last);
      a_err.push_back(bus.err_long);
    end
    if (bus.busy === 1'b1 && !prev_busy) g_log.push_back(int'(bus.out_src));
    prev_busy = (bus.busy === 1'b1);

    acc = 0; lst = 0; own_b = m_own;
    if (!rst) begin
      if (!m_lock) begin
        cand = bus.req_valid;
`ifdef NS_ARB_QOS_EN
        if ((bus.req_valid & bus.req_urgent) != '0) cand = bus.req_valid & bus.req_urgent;
`endif
        // winner = candidate at the smallest forward distance from ptr
        bd = N; best = 0;
        for (int i = 0; i < N; i++) begin
          if (cand[i]) begin
            d = (i - m_ptr + N) % N;
            if (d < bd) begin bd = d; best = i; end
          end
        end
        if (bd < N) begin
          m_lock = 1; m_own = best; m_src = best; m_cnt = 0; m_err = 0;
        end
      end else if (vld[m_own] && bus.out_ready) begin
        acc = 1;
        lst = lst_a[m_own];
        if (!lst && m_cnt == MB - 1) m_err = 1;
        if (m_cnt < MB) m_cnt++;
        if (lst) begin
          m_ptr  = (m_own + 1) % N;
          m_lock = 0;
        end
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (pause[i] > 0) pause[i]--;
    if (acc) begin
      rem[own_b]--;
      bix[own_b]++;
      if (pause_en && rem[own_b] > 0 && $urandom_range(0, 3) == 0)
        pause[own_b] = $urandom_range(1, 2);
    end
    drive();
  endtask

  task automatic drain(input int max, input string tag);
    int k;
    k = 0;
    while (work_left() && k < max) begin
      step();
      k++;
    end
    chk(tag, 64'(work_left()), 64'd0);
  endtask

  initial begin
    int n0, c0, g0, k;
    rst = 1'b1;
    clear_drv();
    reset_model();
    for (int i = 0; i < N; i++) bid[i] = 0;
    drive();
    step();
    step();
    rst = 1'b0;

    // two 2-beat bursts from req0 and req2, one bubble between them
    n0 = a_src.size(); c0 = cyc;
    bq[0].push_back(2); bq[2].push_back(2);
    drive();
    drain(20, "t1_drain");
    chk("t1_beats", 64'(a_src.size() - n0), 64'd4);
    if (a_src.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_src",  64'(a_src[n0+i]), 64'(e1_src[i]));
        chk("t1_cyc",  64'(a_cyc[n0+i] - c0), 64'(e1_cyc[i]));
        chk("t1_last", 64'(a_last[n0+i]), 64'(i % 2));
      end
    end

    // ptr=3 with req3 and req0 pending: 3, then wrap to 0, then 3 again
    g0 = g_log.size();
    bq[3].push_back(1); bq[3].push_back(1); bq[0].push_back(1);
    drive();
    drain(30, "t2_drain");
    chk("t2_grants", 64'(g_log.size() - g0), 64'd3);
    if (g_log.size() >= g0 + 3)
      for (int i = 0; i < 3; i++) chk("t2_order", 64'(g_log[g0+i]), 64'(e2_g[i]));

    // req1 3-beat burst with out_ready toggling
    rdy_mode = 1;
    n0 = a_src.size();
    bq[1].push_back(3);
    drive();
    drain(30, "t3_drain");
    rdy_mode = 0;
    chk("t3_beats", 64'(a_src.size() - n0), 64'd3);
    if (a_src.size() >= n0 + 3)
      for (int i = 0; i < 3; i++) begin
        chk("t3_src",  64'(a_src[n0+i]), 64'd1);
        chk("t3_last", 64'(a_last[n0+i]), 64'(i == 2));
      end

    // 20-beat burst on req2: err_long after the 16th non-last beat, cleared on next grant
    n0 = a_src.size();
    bq[2].push_back(20);
    drive();
    drain(60, "t4_drain");
    chk("t4_beats", 64'(a_src.size() - n0), 64'd20);
    if (a_src.size() >= n0 + 20)
      for (int i = 0; i < 20; i++) chk("t4_err_at_beat", 64'(a_err[n0+i]), 64'(i >= 16));
    chk("t4_sticky", 64'(bus.err_long), 64'd1);
    g0 = g_log.size();
    bq[0].push_back(1);
    drive();
    drain(20, "t4b_drain");
    chk("t4_cleared", 64'(bus.err_long), 64'd0);
    chk("t4_next_owner", 64'(g_log.size() > g0 ? g_log[g0] : -1), 64'd0);

    // reset after beat 2 of a 4-beat burst on req2 (ptr is 1 at this point)
    n0 = a_src.size();
    bq[2].push_back(4);
    drive();
    k = 0;
    while ((a_src.size() - n0) < 2 && k < 20) begin
      step();
      k++;
    end
    chk("t5_two_beats", 64'(a_src.size() - n0), 64'd2);
    chk("t5_locked_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_busy",      64'(bus.busy),      64'd0);
    chk("t5_req_ready", 64'(bus.req_ready), 64'd0);
    chk("t5_out_src",   64'(bus.out_src),   64'd0);
    clear_drv();
    reset_model();
    drive();
    step();
    step();
    rst = 1'b0;
    prev_busy = 0;

    // req0+req1 valid, req1 urgent, ptr restarted from 0
    g0 = g_log.size();
    urg = 4'b0010;
    bq[0].push_back(1); bq[1].push_back(1);
    drive();
    drain(20, "t6_drain");
    chk("t6_first_grant", 64'(g_log.size() > g0 ? g_log[g0] : -1), 64'(QOS_FIRST));
    urg = '0;

    // randomized traffic, ready and urgency, with mid-burst valid gaps
    rdy_mode = 2; pause_en = 1; rnd_urg = 1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (bq[i].size() < 2 && $urandom_range(0, 7) == 0) bq[i].push_back($urandom_range(1, 20));
      step();
    end
    drain(3000, "t7_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ns_gnrl_burst_arb.md
Name: ns_gnrl_burst_arb

Overview:
- Shares one downstream valid/ready beat port between REQ_NUM upstream requesters.
- Ownership is per burst: a grant is decided by round-robin and stays locked until the owner's last beat is accepted downstream.
- Sits between bus masters (fetch, LSU, DMA) and a single memory/interconnect port.
- Round-robin priority advances past the owner when each burst completes.

Parameters:
- REQ_NUM, 4, number of requesters (≥2).
- DW, 32, beat data width.
- MAX_BEATS, 16, burst length above which the long-burst flag is raised.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  REQ_NUM  per-requester beat valid.
- req_data  in  REQ_NUM*DW  per-requester beat data; requester i occupies bits [i*DW +: DW].
- req_last  in  REQ_NUM  per-requester last beat of burst.
- req_ready  out  REQ_NUM  per-requester beat accepted.
- req_urgent  in  REQ_NUM  urgent request hint (used only with NS_ARB_QOS_EN).
- out_valid  out  1  downstream beat valid.
- out_data  out  DW  downstream beat data.
- out_last  out  1  downstream last beat.
- out_ready  in  1  downstream ready.
- out_src  out  $clog2(REQ_NUM)  index of current owner.
- busy  out  1  a burst is locked.
- err_long  out  1  sticky flag: current/last burst exceeded MAX_BEATS beats.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values: state=IDLE, ptr=0, owner=0, beat_cnt=0, out_valid=0, req_ready=0, out_src=0, busy=0, err_long=0. Assertion mid-burst aborts immediately; no beat is completed.
- FSM has two states, IDLE and LOCK.
- IDLE:
  - out_valid=0, req_ready=0.
  - If |req_valid, pick the first requester i with req_valid[i]=1, searching ptr, ptr+1, … with wrap modulo REQ_NUM.
  - Register owner=i, clear beat_cnt and err_long, go to LOCK.
  - Arbitration latency is 1 cycle: the first beat can transfer in the cycle after the request is first seen.
- LOCK, combinational path:
  - out_valid = req_valid[owner]; out_data and out_last are muxed from owner.
  - req_ready[owner] = out_ready; all other req_ready = 0.
  - busy = 1; out_src = owner (out_src holds the last owner while in IDLE).
- Beat accepted = out_valid & out_ready.
  - On each accepted beat, beat_cnt increments, saturating at MAX_BEATS.
  - If an accepted beat has out_last=0 while beat_cnt==MAX_BEATS-1, set err_long. It stays set until the next grant. The burst itself is not cut.
- Accepted beat with out_last=1:
  - ptr = (owner+1) mod REQ_NUM, then go to IDLE.
  - There is always at least one bubble cycle between bursts.
- Owner deasserting req_valid mid-burst: the lock is held and out_valid follows req_valid[owner]. There is no timeout.
- Single-beat burst (last on the first beat) is legal: LOCK lasts one accepted beat.
- Non-owner requests are held pending; they are never dropped and never see ready.
- Wrap: ptr=REQ_NUM-1 followed by a completed burst gives ptr=0.
- Requester inputs must stay stable while valid and not ready (standard valid/ready). The block adds no buffering and no combinational path from out_ready to req_valid.

Optional Feature:
- Macro: NS_ARB_QOS_EN.
- Defined:
  - In IDLE, if any (req_valid & req_urgent) bit is set, the round-robin search from ptr is restricted to urgent requesters.
  - Otherwise the normal round-robin over req_valid applies.
  - Urgency never preempts a locked burst.
  - ptr update is unchanged (owner+1).
- Undefined: req_urgent is ignored (port kept, unused); pure round-robin.

Test Plan:
- Reset, then req_valid=4'b0101, each requester sends a 2-beat burst, out_ready=1 -> grants req0 (out_src=0) on 2 beats, 1 bubble cycle, then req2 on 2 beats; ptr=3 after.
- ptr=3, req_valid=4'b1001 -> req3 served first, then req0 (wrap), then req3 again only after req0 finishes.
- Owner 1 in LOCK, out_ready toggles 1,0,1,0 with a 3-beat burst -> req_ready[1] mirrors out_ready, other req_ready=0, exactly 3 accepted beats, out_last on the 3rd.
- MAX_BEATS=16, owner sends a 20-beat burst -> err_long rises on the 16th non-last accepted beat, all 20 beats pass, err_long clears at the next grant.
- rst asserted after beat 2 of a 4-beat burst -> same cycle: out_valid=0, busy=0, req_ready=0; after release, arbitration restarts from ptr=0.
- With NS_ARB_QOS_EN: ptr=0, req_valid=4'b0011, req_urgent=4'b0010 -> req1 granted first. Without the macro -> req0 granted first.
